// File: rtl/permutation_round_scheduler.sv
// Round sequencer for the Ascon permutation datapath: walks the round index for
// p12 (0..11) or p6 (6..11) and drives datapath input-select and state enable.
module permutation_round_scheduler #(
  parameter int unsigned ROUND_W       = 4,
  parameter int unsigned LAST_ROUND    = 11,
  parameter int unsigned FIRST_ROUND_A = 0,
  parameter int unsigned FIRST_ROUND_B = 6
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               mode_i,
  input  logic               stall_i,
  output logic [ROUND_W-1:0] round_o,
  output logic               state_sel_o,
  output logic               state_en_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [ROUND_W-1:0] LastRound  = ROUND_W'(LAST_ROUND);
  localparam logic [ROUND_W-1:0] FirstRndA  = ROUND_W'(FIRST_ROUND_A);
  localparam logic [ROUND_W-1:0] FirstRndB  = ROUND_W'(FIRST_ROUND_B);

  state_e               state_q, state_d;
  logic [ROUND_W-1:0]   round_q, round_d;
  logic                 first_q, first_d;

  // State, round counter and first-round flag registers
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      round_q <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      first_q <= first_d;
    end
  end

  // Next-state: a start is accepted from IDLE or DONE; stalls freeze RUN
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    first_d = first_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          round_d = mode_i ? FirstRndA : FirstRndB;
          first_d = 1'b1;
        end
      end
      RUN: begin
        if (!stall_i) begin
          first_d = 1'b0;
          if (round_q == LastRound) begin
            state_d = DONE;
          end else begin
            round_d = round_q + ROUND_W'(1);
          end
        end
      end
      DONE: begin
        if (start_i) begin
          state_d = RUN;
          round_d = mode_i ? FirstRndA : FirstRndB;
          first_d = 1'b1;
        end else begin
          state_d = IDLE;
          round_d = '0;
          first_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        round_d = '0;
        first_d = 1'b0;
      end
    endcase
  end

  // Outputs decode registered state; state_en_o alone follows stall_i so a
  // stalled cycle never loads the state register.
  always_comb begin
    round_o     = round_q;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    state_sel_o = 1'b0;
    state_en_o  = 1'b0;
    unique case (state_q)
      RUN: begin
        busy_o      = 1'b1;
        state_sel_o = first_q;
        state_en_o  = ~stall_i;
      end
      DONE: begin
        done_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
